ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage CPU. Sits between the ID/EX register and the memory stage, and drives the EX/MEM pipeline register (ex_en, ex_mem_op, ex_mem_wr_data, ex_dst_addr, ex_gpr_we_, ex_out).
- Single-cycle ALU plus an iterative radix-2 divider.
- While the divider runs, the stage asserts md_stall to freeze upstream stages.

Parameters:
- WORD_W, 32, datapath width
- REG_ADDR_W, 5, GPR address width
- MEM_OP_W, 4, memory-op field width; bits [3:2]==0 means no access
- ALU_OP_W, 4, ALU opcode width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  global pipeline stall (includes dcache miss_stall)
- flush  in  1  flush EX/MEM register and abort divider
- id_en  in  1  ID/EX entry valid
- id_alu_op  in  4  operation
- id_alu_in_0  in  32  operand A
- id_alu_in_1  in  32  operand B
- id_mem_op  in  4  passed through
- id_mem_wr_data  in  32  passed through
- id_dst_addr  in  5  passed through
- id_gpr_we_  in  1  GPR write enable, active-low, passed through
- fwd_data  out  32  combinational result, used for forwarding
- md_stall  out  1  divider busy; requests upstream stall
- ex_en  out  1  EX/MEM valid
- ex_mem_op  out  4  registered
- ex_mem_wr_data  out  32  registered
- ex_dst_addr  out  5  registered
- ex_gpr_we_  out  1  registered, active-low
- ex_out  out  32  registered result

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Reset values: ex_en=0, ex_mem_op=0, ex_mem_wr_data=0, ex_dst_addr=0, ex_gpr_we_=1, ex_out=0, divider FSM=IDLE, md_stall=0.
- Opcodes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, MUL A (low 32 bits), MULH B (signed high 32), DIV C, DIVU D, REM E, REMU F.
- Shift amount is in_1[4:0]. ADD/SUB wrap modulo 2^32. SLT/SLTU produce 0 or 1.
- ALU ops 0..B: result combinational, latency 1 (ex_out valid the cycle after capture).
- Capture rule, evaluated at the clock edge:
  - flush: ex_en=0, ex_gpr_we_=1, ex_mem_op=0; other fields don't-care.
  - else stall or md_stall: hold all outputs.
  - else: load id_* fields and result. If id_en=0, ex_gpr_we_=1 and ex_mem_op=0.
- Divider FSM: IDLE -> BUSY -> DONE.
  - IDLE: when id_en and op in C..F, md_stall=1. Latch magnitudes and signs, cnt=0, go to BUSY.
  - BUSY: one quotient bit per cycle. md_stall=1. After cnt==31, go to DONE.
  - DONE: md_stall=0 and fwd_data=div result. Go to IDLE on the edge where the result is captured (stall=0) or on flush. If stall=1, stay in DONE holding the result.
- Div latency: op presented in cycle 0, DONE in cycle 33, ex_out visible in cycle 34 (stall=0 throughout).
- Global stall asserted during BUSY does not pause the iteration.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. Handled in the IDLE cycle: go straight to DONE next cycle, latency 2.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0, latency 2.
- Signed results: quotient sign = sa^sb; remainder sign = sign of dividend.
- flush in any divider state: return to IDLE next cycle, md_stall=0 that cycle, no result written.
- reset mid-division: identical to the reset values above.

Optional Feature:
- Macro: EX_DIV_EN.
- Defined: iterative divider and md_stall as specified above.
- Undefined: divider omitted; ops C..F produce 0 in a single cycle; md_stall is tied to 0.

Decomposition:
- Shared package/header ex_pkg: ALU_OP_* opcode constants, widths, divider state enum (DIV_IDLE, DIV_BUSY, DIV_DONE).
- Sub-module ex_div holds the FSM, 5-bit counter, remainder/quotient shift registers, and sign fix-up.
- ALU and EX/MEM register stay in ex_stage.

Test Plan:
- ADD 0x7FFFFFFF+1 with id_en=1, dst=3 -> next cycle ex_out=0x80000000, ex_en=1, ex_dst_addr=3, md_stall never asserted.
- DIV 100/7 presented at cycle 0 -> md_stall=1 cycles 0..32, ex_out=14 at cycle 34. REM -100/7 -> ex_out=0xFFFFFFFE (-2).
- DIVU x/0 with x=0x1234 -> ex_out=0xFFFFFFFF after 2 cycles. REMU x/0 -> ex_out=0x1234.
- DIV 0x80000000/0xFFFFFFFF -> ex_out=0x80000000. REM of the same operands -> 0.
- flush at cycle 10 of a DIV -> md_stall=0 at cycle 11, ex_en=0. A new ADD issued next is captured normally.
- stall=1 held for 5 cycles from cycle 33 -> FSM stays in DONE, ex_out unchanged until stall drops, then quotient is captured once.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcodes and divider states.
package ex_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MEM_OP_W   = 4;
    localparam int ALU_OP_W   = 4;
    localparam int SHAMT_W    = $clog2(WORD_W);

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_ADD  = 4'h0,
        ALU_OP_SUB  = 4'h1,
        ALU_OP_AND  = 4'h2,
        ALU_OP_OR   = 4'h3,
        ALU_OP_XOR  = 4'h4,
        ALU_OP_SLL  = 4'h5,
        ALU_OP_SRL  = 4'h6,
        ALU_OP_SRA  = 4'h7,
        ALU_OP_SLT  = 4'h8,
        ALU_OP_SLTU = 4'h9,
        ALU_OP_MUL  = 4'hA,
        ALU_OP_MULH = 4'hB,
        ALU_OP_DIV  = 4'hC,
        ALU_OP_DIVU = 4'hD,
        ALU_OP_REM  = 4'hE,
        ALU_OP_REMU = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    // Opcodes C..F share the top two bits; bit 0 clear = signed, bit 1 set = remainder.
    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider with sign fix-up; present only when EX_DIV_EN is defined.
`ifdef EX_DIV_EN
module ex_div
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              start,
    input  logic              op_signed,
    input  logic              op_rem,
    input  logic [WORD_W-1:0] dividend,
    input  logic [WORD_W-1:0] divisor,
    output logic              busy,
    output logic [WORD_W-1:0] result
);

    div_state_e        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] quo_q, quo_d;
    logic [WORD_W-1:0] rem_q, rem_d;
    logic [WORD_W-1:0] dvs_q, dvs_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              sel_rem_q, sel_rem_d;

    logic [WORD_W-1:0] a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [WORD_W:0]   shifted, diff;

    always_comb begin
        a_mag    = (op_signed && dividend[WORD_W-1]) ? -dividend : dividend;
        b_mag    = (op_signed && divisor[WORD_W-1])  ? -divisor  : divisor;
        div_zero = (divisor == '0);
        div_ovf  = op_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        shifted  = {rem_q, quo_q[WORD_W-1]};
        diff     = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        // NOTE: every flop gets a non-blocking update so all registers see the pre-edge values.
        if (reset) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            sel_rem_q <= sel_rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (start) state_d = (div_zero || div_ovf) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (flush)               state_d = DIV_IDLE;
                else if (cnt_q == 5'd31) state_d = DIV_DONE;
            end
            DIV_DONE: if (flush || !stall) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: hold-value defaults first, so no path through this block can infer a latch.
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        sel_rem_d = sel_rem_q;
        if (state_q == DIV_IDLE && start) begin
            sel_rem_d = op_rem;
            dvs_d     = b_mag;
            cnt_d     = '0;
            q_neg_d   = 1'b0;
            r_neg_d   = 1'b0;
            if (div_zero) begin
                quo_d = '1;
                rem_d = dividend;
            end else if (div_ovf) begin
                quo_d = 32'h8000_0000;
                rem_d = '0;
            end else begin
                quo_d   = a_mag;
                rem_d   = '0;
                q_neg_d = op_signed && (dividend[WORD_W-1] ^ divisor[WORD_W-1]);
                r_neg_d = op_signed && dividend[WORD_W-1];
            end
        end else if (state_q == DIV_BUSY) begin
            // Quotient bits shift in where dividend bits shift out.
            cnt_d = cnt_q + 5'd1;
            quo_d = {quo_q[WORD_W-2:0], ~diff[WORD_W]};
            rem_d = diff[WORD_W] ? shifted[WORD_W-1:0] : diff[WORD_W-1:0];
        end
    end

    always_comb begin
        busy   = (state_q == DIV_BUSY) || (state_q == DIV_IDLE && start);
        result = sel_rem_q ? (r_neg_q ? -rem_q : rem_q)
                           : (q_neg_q ? -quo_q : quo_q);
    end

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU and EX/MEM register; define EX_DIV_EN to add the
// iterative divider (ops C..F) and its md_stall request, otherwise those ops yield 0.
module ex_stage
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_en,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [WORD_W-1:0]     id_alu_in_0,
    input  logic [WORD_W-1:0]     id_alu_in_1,
    input  logic [MEM_OP_W-1:0]   id_mem_op,
    input  logic [WORD_W-1:0]     id_mem_wr_data,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_gpr_we_,
    output logic [WORD_W-1:0]     fwd_data,
    output logic                  md_stall,
    output logic                  ex_en,
    output logic [MEM_OP_W-1:0]   ex_mem_op,
    output logic [WORD_W-1:0]     ex_mem_wr_data,
    output logic [REG_ADDR_W-1:0] ex_dst_addr,
    output logic                  ex_gpr_we_,
    output logic [WORD_W-1:0]     ex_out
);

    logic [WORD_W-1:0]          a, b, alu_res;
    logic [SHAMT_W-1:0]         shamt;
    logic signed [2*WORD_W-1:0] a_sx, b_sx, prod_s;

    always_comb begin
        a      = id_alu_in_0;
        b      = id_alu_in_1;
        shamt  = b[SHAMT_W-1:0];
        a_sx   = {{WORD_W{a[WORD_W-1]}}, a};
        b_sx   = {{WORD_W{b[WORD_W-1]}}, b};
        prod_s = a_sx * b_sx;
    end

    always_comb begin
        alu_res = '0;
        case (id_alu_op)
            ALU_OP_ADD:  alu_res = a + b;
            ALU_OP_SUB:  alu_res = a - b;
            ALU_OP_AND:  alu_res = a & b;
            ALU_OP_OR:   alu_res = a | b;
            ALU_OP_XOR:  alu_res = a ^ b;
            ALU_OP_SLL:  alu_res = a << shamt;
            ALU_OP_SRL:  alu_res = a >> shamt;
            ALU_OP_SRA:  alu_res = $signed(a) >>> shamt;
            ALU_OP_SLT:  alu_res = {{(WORD_W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_OP_SLTU: alu_res = {{(WORD_W-1){1'b0}}, a < b};
            ALU_OP_MUL:  alu_res = prod_s[WORD_W-1:0];
            ALU_OP_MULH: alu_res = prod_s[2*WORD_W-1:WORD_W];
            default:     alu_res = '0;
        endcase
    end

`ifdef EX_DIV_EN
    logic              div_start;
    logic [WORD_W-1:0] div_res;

    // A flushed entry must never launch a division.
    assign div_start = id_en && is_div_op(id_alu_op) && !flush;

    ex_div u_div (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .stall     (stall),
        .start     (div_start),
        .op_signed (!id_alu_op[0]),
        .op_rem    (id_alu_op[1]),
        .dividend  (a),
        .divisor   (b),
        .busy      (md_stall),
        .result    (div_res)
    );

    assign fwd_data = is_div_op(id_alu_op) ? div_res : alu_res;
`else
    assign md_stall = 1'b0;
    assign fwd_data = alu_res;
`endif

    logic                  en_q, en_d;
    logic [MEM_OP_W-1:0]   mem_op_q, mem_op_d;
    logic [WORD_W-1:0]     wr_data_q, wr_data_d;
    logic [REG_ADDR_W-1:0] dst_q, dst_d;
    logic                  gpr_we_q, gpr_we_d;
    logic [WORD_W-1:0]     out_q, out_d;

    always_comb begin
        en_d      = en_q;
        mem_op_d  = mem_op_q;
        wr_data_d = wr_data_q;
        dst_d     = dst_q;
        gpr_we_d  = gpr_we_q;
        out_d     = out_q;
        if (flush) begin
            en_d     = 1'b0;
            gpr_we_d = 1'b1;
            mem_op_d = '0;
        end else if (!(stall || md_stall)) begin
            // Bubbles must not write the register file or touch memory.
            en_d      = id_en;
            mem_op_d  = id_en ? id_mem_op : '0;
            wr_data_d = id_mem_wr_data;
            dst_d     = id_dst_addr;
            gpr_we_d  = id_en ? id_gpr_we_ : 1'b1;
            out_d     = fwd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q      <= 1'b0;
            mem_op_q  <= '0;
            wr_data_q <= '0;
            dst_q     <= '0;
            gpr_we_q  <= 1'b1;
            out_q     <= '0;
        end else begin
            en_q      <= en_d;
            mem_op_q  <= mem_op_d;
            wr_data_q <= wr_data_d;
            dst_q     <= dst_d;
            gpr_we_q  <= gpr_we_d;
            out_q     <= out_d;
        end
    end

    assign ex_en          = en_q;
    assign ex_mem_op      = mem_op_q;
    assign ex_mem_wr_data = wr_data_q;
    assign ex_dst_addr    = dst_q;
    assign ex_gpr_we_     = gpr_we_q;
    assign ex_out         = out_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with a scoreboard of expected EX/MEM contents.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_en, id_gpr_we_;
    logic [3:0]  id_alu_op, id_mem_op;
    logic [31:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data;
    logic [4:0]  id_dst_addr;
    logic [31:0] fwd_data, ex_mem_wr_data, ex_out;
    logic        md_stall, ex_en, ex_gpr_we_;
    logic [3:0]  ex_mem_op;
    logic [4:0]  ex_dst_addr;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] last_out = '0;

    typedef struct {
        string       tag;
        logic [31:0] out;
        logic [4:0]  dst;
        logic        we_n;
        logic [3:0]  mop;
        logic [31:0] wd;
    } exp_t;
    exp_t sb[$];

    ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .id_en          (id_en),
        .id_alu_op      (id_alu_op),
        .id_alu_in_0    (id_alu_in_0),
        .id_alu_in_1    (id_alu_in_1),
        .id_mem_op      (id_mem_op),
        .id_mem_wr_data (id_mem_wr_data),
        .id_dst_addr    (id_dst_addr),
        .id_gpr_we_     (id_gpr_we_),
        .fwd_data       (fwd_data),
        .md_stall       (md_stall),
        .ex_en          (ex_en),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_out         (ex_out)
    );

    always #5 clk = ~clk;

    localparam int N_ALU = 15;
    logic [3:0]  t_op [N_ALU] = '{ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_SLL,
                                  ALU_OP_SRL, ALU_OP_SRA, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_MUL,
                                  ALU_OP_MULH, ALU_OP_MULH, ALU_OP_SUB, ALU_OP_SRA, ALU_OP_SLT};
    logic [31:0] t_a  [N_ALU] = '{32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1,
                                  32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h10000,
                                  32'hFFFFFFFF, 32'h40000000, 32'h0, 32'h7FFFFFF0, 32'h1};
    logic [31:0] t_b  [N_ALU] = '{32'h7, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h24,
                                  32'd31, 32'h4, 32'h1, 32'h1, 32'h10001,
                                  32'h2, 32'h4, 32'h1, 32'h44, 32'hFFFFFFFF};
    logic [31:0] t_x  [N_ALU] = '{32'hFFFFFFFE, 32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h10,
                                  32'h1, 32'hF8000000, 32'h1, 32'h0, 32'h00010000,
                                  32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h07FFFFFF, 32'h0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dst, input logic we_n,
                         input logic [3:0] mop, input logic [31:0] wd);
        id_en          = en;
        id_alu_op      = op;
        id_alu_in_0    = a;
        id_alu_in_1    = b;
        id_dst_addr    = dst;
        id_gpr_we_     = we_n;
        id_mem_op      = mop;
        id_mem_wr_data = wd;
    endtask

    task automatic bubble();
        drive(1'b0, ALU_OP_ADD, '0, '0, '0, 1'b1, '0, '0);
    endtask

    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dst, input logic [31:0] exp);
        exp_t e;
        drive(1'b1, op, a, b, dst, 1'b0, 4'h0, a ^ b);
        e = '{tag: tag, out: exp, dst: dst, we_n: 1'b0, mop: 4'h0, wd: a ^ b};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".ex_en"},   32'(ex_en),          32'd1);
            check({e.tag, ".ex_out"},  ex_out,              e.out);
            check({e.tag, ".dst"},     32'(ex_dst_addr),    32'(e.dst));
            check({e.tag, ".gpr_we_"}, 32'(ex_gpr_we_),     32'(e.we_n));
            check({e.tag, ".mem_op"},  32'(ex_mem_op),      32'(e.mop));
            check({e.tag, ".wr_data"}, ex_mem_wr_data,      e.wd);
            last_out = e.out;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".ex_en"},    32'(ex_en),       32'd0);
        check({tag, ".ex_out"},   ex_out,           32'd0);
        check({tag, ".gpr_we_"},  32'(ex_gpr_we_),  32'd1);
        check({tag, ".mem_op"},   32'(ex_mem_op),   32'd0);
        check({tag, ".wr_data"},  ex_mem_wr_data,   32'd0);
        check({tag, ".dst"},      32'(ex_dst_addr), 32'd0);
        check({tag, ".md_stall"}, 32'(md_stall),    32'd0);
    endtask

`ifdef EX_DIV_EN
    // n_busy: number of cycles md_stall is expected high, starting with the issue cycle.
    task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int n_busy);
        issue(tag, op, a, b, 5'd8, exp);
        settle();
        for (int c = 0; c < n_busy; c++) begin
            check({tag, ".md_stall_busy"}, 32'(md_stall), 32'd1);
            tick();
        end
        check({tag, ".md_stall_done"}, 32'(md_stall), 32'd0);
        check({tag, ".fwd_data"},      fwd_data,      exp);
        tick();
        bubble();
        settle();
        pop_check();
    endtask
`endif

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        bubble();
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;

        issue("add_wrap", ALU_OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd3, 32'h80000000);
        settle();
        check("add_wrap.fwd_data", fwd_data, 32'h80000000);
        check("add_wrap.md_stall", 32'(md_stall), 32'd0);
        tick();
        pop_check();
        check("add_wrap.md_stall_after", 32'(md_stall), 32'd0);

        for (int i = 0; i < N_ALU; i++) begin
            issue($sformatf("alu%0d", i), t_op[i], t_a[i], t_b[i], 5'(i + 1), t_x[i]);
            settle();
            check($sformatf("alu%0d.fwd_data", i), fwd_data, t_x[i]);
            tick();
            pop_check();
        end

        begin
            exp_t e;
            drive(1'b1, ALU_OP_ADD, 32'd10, 32'd20, 5'd7, 1'b1, 4'b0110, 32'hDEADBEEF);
            e = '{tag: "mem_pass", out: 32'd30, dst: 5'd7, we_n: 1'b1, mop: 4'b0110, wd: 32'hDEADBEEF};
            sb.push_back(e);
            tick();
            pop_check();
        end

        drive(1'b0, ALU_OP_ADD, 32'd1, 32'd1, 5'd9, 1'b0, 4'b0101, 32'h1);
        tick();
        check("bubble.ex_en",   32'(ex_en),      32'd0);
        check("bubble.gpr_we_", 32'(ex_gpr_we_), 32'd1);
        check("bubble.mem_op",  32'(ex_mem_op),  32'd0);

        issue("pre_stall", ALU_OP_ADD, 32'd1, 32'd1, 5'd4, 32'd2);
        tick();
        pop_check();
        stall = 1'b1;
        drive(1'b1, ALU_OP_XOR, 32'hFF, 32'h0F, 5'd6, 1'b0, 4'h0, 32'hFF ^ 32'h0F);
        tick();
        tick();
        check("stall_hold.ex_out", ex_out,           32'd2);
        check("stall_hold.dst",    32'(ex_dst_addr), 32'd4);
        stall = 1'b0;
        issue("after_stall", ALU_OP_XOR, 32'hFF, 32'h0F, 5'd6, 32'hF0);
        tick();
        pop_check();

        issue("flushed_add", ALU_OP_ADD, 32'd5, 32'd5, 5'd10, 32'd10);
        void'(sb.pop_back());
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("alu_flush.ex_en",   32'(ex_en),      32'd0);
        check("alu_flush.gpr_we_", 32'(ex_gpr_we_), 32'd1);
        check("alu_flush.mem_op",  32'(ex_mem_op),  32'd0);
        bubble();

`ifdef EX_DIV_EN
        tick();
        run_div("div_100_7",    ALU_OP_DIV,  32'd100,      32'd7,          32'd14,        33);
        run_div("rem_m100_7",   ALU_OP_REM,  32'hFFFFFF9C, 32'd7,          32'hFFFFFFFE,  33);
        run_div("div_m100_7",   ALU_OP_DIV,  32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,  33);
        run_div("rem_100_m7",   ALU_OP_REM,  32'd100,      32'hFFFFFFF9,   32'd2,         33);
        run_div("divu_max_3",   ALU_OP_DIVU, 32'hFFFFFFFF, 32'd3,          32'h55555555,  33);
        run_div("divu_by0",     ALU_OP_DIVU, 32'h1234,     32'd0,          32'hFFFFFFFF,  1);
        run_div("remu_by0",     ALU_OP_REMU, 32'h1234,     32'd0,          32'h1234,      1);
        run_div("div_ovf",      ALU_OP_DIV,  32'h80000000, 32'hFFFFFFFF,   32'h80000000,  1);
        run_div("rem_ovf",      ALU_OP_REM,  32'h80000000, 32'hFFFFFFFF,   32'd0,         1);

        issue("pre_flush", ALU_OP_ADD, 32'd1, 32'd1, 5'd1, 32'd2);
        tick();
        pop_check();
        drive(1'b1, ALU_OP_DIV, 32'd100, 32'd7, 5'd8, 1'b0, 4'h0, 32'h0);
        for (int c = 0; c < 10; c++) tick();
        flush = 1'b1;
        settle();
        check("div_flush.md_stall_c10", 32'(md_stall), 32'd1);
        tick();
        flush = 1'b0;
        issue("add_after_flush", ALU_OP_ADD, 32'd2, 32'd3, 5'd5, 32'd5);
        settle();
        check("div_flush.md_stall_c11", 32'(md_stall),   32'd0);
        check("div_flush.ex_en",        32'(ex_en),      32'd0);
        check("div_flush.gpr_we_",      32'(ex_gpr_we_), 32'd1);
        tick();
        pop_check();

        issue("div_stalled", ALU_OP_DIV, 32'd100, 32'd7, 5'd8, 32'd14);
        settle();
        for (int c = 0; c < 33; c++) begin
            if (c == 5) stall = 1'b1;
            if (c == 9) stall = 1'b0;
            check("div_stalled.md_stall_busy", 32'(md_stall), 32'd1);
            tick();
        end
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("div_stalled.md_stall_done", 32'(md_stall), 32'd0);
            check("div_stalled.fwd_data",      fwd_data,      32'd14);
            check("div_stalled.ex_out_held",   ex_out,        last_out);
            tick();
        end
        stall = 1'b0;
        settle();
        check("div_stalled.ex_out_held_c38", ex_out, last_out);
        tick();
        pop_check();
        bubble();
        settle();
        check("div_stalled.idle_md_stall", 32'(md_stall), 32'd0);
        tick();
        check("div_stalled.captured_once", 32'(ex_en), 32'd0);

        drive(1'b1, ALU_OP_DIV, 32'd100, 32'd7, 5'd8, 1'b0, 4'h0, 32'h0);
        for (int c = 0; c < 5; c++) tick();
        reset = 1'b1;
        bubble();
        tick();
        check_reset_state("reset_mid_div");
        reset = 1'b0;
        tick();
        check("reset_mid_div.md_stall_after", 32'(md_stall), 32'd0);
        run_div("divu_by0_after_reset", ALU_OP_DIVU, 32'h55, 32'd0, 32'hFFFFFFFF, 1);
`else
        tick();
        issue("pre_nodiv", ALU_OP_ADD, 32'd40, 32'd2, 5'd2, 32'd42);
        tick();
        pop_check();
        for (int i = 0; i < 4; i++) begin
            issue($sformatf("nodiv%0d", i), 4'(12 + i), 32'd100, 32'(i & 1) * 32'd7, 5'd9, 32'd0);
            settle();
            check($sformatf("nodiv%0d.md_stall", i), 32'(md_stall), 32'd0);
            check($sformatf("nodiv%0d.fwd_data", i), fwd_data,      32'd0);
            tick();
            pop_check();
        end
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
